// File: rtl/us_pkg.sv
// Shared types and helpers for the multi-channel ultrasonic ranger.
package us_pkg;

  typedef enum logic [2:0] {
    IDLE,
    TRIG,
    WAIT_RISE,
    MEASURE,
    DONE,
    HOLD
  } us_state_t;

  // Round-trip echo time for one centimetre, in microseconds.
  localparam int CM_PER_US_DIV = 58;

  // Converts a duration in microseconds to clock cycles (truncating).
  // The product is formed in 64 bits so that long timeouts at high clock rates
  // do not overflow.
  function automatic int us_to_cyc(input longint us, input longint clk_hz);
    return int'((us * clk_hz) / longint'(1_000_000));
  endfunction

endpackage

// File: rtl/us_ranger_array_if.sv
// Pin-level bundle between the ranger and its surroundings: control inputs,
// raw echo pins, trigger pins and the per-channel result outputs.
interface us_ranger_array_if #(
  parameter int N_CH   = 2,
  parameter int DIST_W = 9
);
  logic                     enable;
  logic                     measure;
  logic [N_CH-1:0]          echo;
  logic [N_CH-1:0]          trig;
  logic [N_CH*DIST_W-1:0]   distance;
  logic [N_CH-1:0]          valid;
  logic [N_CH-1:0]          timeout;
  logic [N_CH-1:0]          near;
  logic                     busy;

  // Controller / pin side that drives control and echo and reads results.
  modport master (
    output enable, measure, echo,
    input  trig, distance, valid, timeout, near, busy
  );

  // The ranger itself.
  modport slave (
    input  enable, measure, echo,
    output trig, distance, valid, timeout, near, busy
  );
endinterface

// File: rtl/us_echo_sync.sv
// Two-flop synchronizer for one raw echo pin, plus a third register that turns
// the synchronized level into single-cycle rise/fall pulses. Both edges see the
// same delay, so measured pulse widths are not skewed.
module us_echo_sync (
  input  logic clk,
  input  logic rst,
  input  logic echo,
  output logic rise,
  output logic fall
);
  logic sync1_reg;
  logic sync2_reg;
  logic edge_reg;

  // Synchronizer chain plus the edge-detect history register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_reg <= 1'b0;
      sync2_reg <= 1'b0;
      edge_reg  <= 1'b0;
    end else begin
      sync1_reg <= echo;
      sync2_reg <= sync1_reg;
      edge_reg  <= sync2_reg;
    end
  end

  assign rise = sync2_reg & ~edge_reg;
  assign fall = ~sync2_reg & edge_reg;
endmodule

// File: rtl/us_ranger_array.sv
// Round-robin driver for up to eight HC-SR04-style sensors. One shared set of
// timers serves whichever channel owns the current slot; per channel only the
// filtered distance, first-sample flag, timeout flag and near flag are kept.
module us_ranger_array
  import us_pkg::*;
#(
  parameter int N_CH       = 2,
  parameter int CLK_HZ     = 50_000_000,
  parameter int TRIG_US    = 10,
  parameter int TIMEOUT_US = 30000,
  parameter int SLOT_MS    = 60,
  parameter int DIST_W     = 9,
  parameter int AVG_LOG2   = 2,
  parameter int NEAR_CM    = 20
) (
  input logic              clk,
  input logic              rst,
  us_ranger_array_if.slave bus
);
  localparam int TRIG_CYC = us_to_cyc(TRIG_US, CLK_HZ);
  localparam int CM_CYC   = us_to_cyc(CM_PER_US_DIV, CLK_HZ);
  localparam int TO_CYC   = us_to_cyc(TIMEOUT_US, CLK_HZ);
  localparam int SLOT_CYC = us_to_cyc(longint'(SLOT_MS) * 1000, CLK_HZ);

  localparam int TMR_MAX = (TO_CYC > TRIG_CYC) ? TO_CYC : TRIG_CYC;
  localparam int TMR_W   = $clog2(TMR_MAX + 1);
  localparam int PRE_W   = $clog2(CM_CYC + 1);
  localparam int SLOT_W  = $clog2(SLOT_CYC + 1);
  localparam int CH_W    = (N_CH > 1) ? $clog2(N_CH) : 1;

  localparam logic [TMR_W-1:0]  TRIG_LAST = TMR_W'(TRIG_CYC - 1);
  localparam logic [TMR_W-1:0]  TO_LAST   = TMR_W'(TO_CYC - 1);
  localparam logic [PRE_W-1:0]  PRE_LAST  = PRE_W'(CM_CYC - 1);
  localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(SLOT_CYC - 1);
  localparam logic [CH_W-1:0]   CH_LAST   = CH_W'(N_CH - 1);

  us_state_t state_reg, state_next;
  logic [CH_W-1:0]   ch_reg, ch_next;
  logic [TMR_W-1:0]  tmr_reg, tmr_next;       // trigger width, then echo timeout
  logic [PRE_W-1:0]  presc_reg, presc_next;   // cycles within the current cm
  logic [DIST_W-1:0] cm_reg, cm_next;         // raw width of this echo in cm
  logic [SLOT_W-1:0] slot_reg, slot_next;     // cycles since trigger rise
  logic              to_flag_reg, to_flag_next;
  logic              one_shot_reg, one_shot_next;
  logic [N_CH-1:0]   trig_reg, trig_next;
  logic [N_CH-1:0]   valid_reg, valid_next;

  logic [DIST_W-1:0] avg_reg [N_CH];
  logic [DIST_W-1:0] avg_next [N_CH];
  logic [N_CH-1:0]   first_reg, first_next;
  logic [N_CH-1:0]   timeout_reg, timeout_next;
  logic [N_CH-1:0]   near_reg, near_next;

  logic [N_CH-1:0]   rise;
  logic [N_CH-1:0]   fall;
  logic              advance;

  logic [DIST_W-1:0]   avg_cur;
  logic signed [DIST_W:0] diff;
  logic signed [DIST_W:0] filt;
  logic [DIST_W-1:0]   sample;
  logic                sample_near;

  for (genvar gi = 0; gi < N_CH; gi++) begin : g_ch
    us_echo_sync u_sync (
      .clk  (clk),
      .rst  (rst),
      .echo (bus.echo[gi]),
      .rise (rise[gi]),
      .fall (fall[gi])
    );
    assign bus.distance[gi*DIST_W +: DIST_W] = avg_reg[gi];
  end

  // IIR step in signed DIST_W+1 bits; the result always lies between the old
  // average and the new sample, so truncating back to DIST_W bits is exact.
  assign avg_cur     = avg_reg[ch_reg];
  assign diff        = $signed({1'b0, cm_reg}) - $signed({1'b0, avg_cur});
  assign filt        = $signed({1'b0, avg_cur}) + (diff >>> AVG_LOG2);
  assign sample      = first_reg[ch_reg] ? cm_reg : DIST_W'(filt);
  assign sample_near = (32'(sample) < 32'(NEAR_CM));

  // Next-state, shared timers and per-channel result updates.
  always_comb begin
    state_next    = state_reg;
    ch_next       = ch_reg;
    tmr_next      = tmr_reg;
    presc_next    = presc_reg;
    cm_next       = cm_reg;
    slot_next     = (slot_reg == SLOT_LAST) ? slot_reg : slot_reg + 1'b1;
    to_flag_next  = to_flag_reg;
    one_shot_next = one_shot_reg & ~bus.enable;
    avg_next      = avg_reg;
    first_next    = first_reg;
    timeout_next  = timeout_reg;
    near_next     = near_reg;
    valid_next    = '0;
    trig_next     = '0;
    advance       = 1'b0;

    case (state_reg)
      IDLE: begin
        ch_next = '0;
        if (bus.enable || bus.measure) begin
          state_next    = TRIG;
          tmr_next      = '0;
          slot_next     = '0;
          // A sweep started by measure alone runs through every channel even
          // though enable is low.
          one_shot_next = ~bus.enable;
        end
      end
      TRIG: begin
        if (tmr_reg == TRIG_LAST) begin
          state_next   = WAIT_RISE;
          tmr_next     = '0;
          to_flag_next = 1'b0;
        end else begin
          tmr_next = tmr_reg + 1'b1;
        end
      end
      WAIT_RISE: begin
        presc_next = '0;
        cm_next    = '0;
        tmr_next   = tmr_reg + 1'b1;
        if (rise[ch_reg]) begin
          state_next = MEASURE;
        end else if (tmr_reg == TO_LAST) begin
          state_next   = DONE;
          to_flag_next = 1'b1;
        end
      end
      MEASURE: begin
        // The closing-edge cycle is counted too, so cm = floor(width/CM_CYC).
        if (presc_reg == PRE_LAST) begin
          presc_next = '0;
          if (cm_reg != '1) cm_next = cm_reg + 1'b1;
        end else begin
          presc_next = presc_reg + 1'b1;
        end
        tmr_next = tmr_reg + 1'b1;
        if (fall[ch_reg]) begin
          state_next = DONE;
        end else if (tmr_reg == TO_LAST) begin
          state_next   = DONE;
          to_flag_next = 1'b1;
        end
      end
      DONE: begin
        valid_next[ch_reg] = 1'b1;
        if (to_flag_reg) begin
          timeout_next[ch_reg] = 1'b1;
        end else begin
          avg_next[ch_reg]     = sample;
          first_next[ch_reg]   = 1'b0;
          timeout_next[ch_reg] = 1'b0;
          near_next[ch_reg]    = sample_near;
        end
        // A late echo may already have used up the slot: skip HOLD entirely.
        if (slot_reg == SLOT_LAST) advance = 1'b1;
        else state_next = HOLD;
      end
      HOLD: begin
        if (slot_reg == SLOT_LAST) advance = 1'b1;
      end
      default: state_next = IDLE;
    endcase

    if (advance) begin
      if (!bus.enable && (!one_shot_reg || ch_reg == CH_LAST)) begin
        state_next = IDLE;
        ch_next    = '0;
      end else begin
        state_next = TRIG;
        ch_next    = (ch_reg == CH_LAST) ? '0 : ch_reg + 1'b1;
        tmr_next   = '0;
        slot_next  = '0;
      end
    end

    if (state_next == TRIG) trig_next[ch_next] = 1'b1;
  end

  // State and datapath registers; reset drops trig at once and discards any
  // sample in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg    <= IDLE;
      ch_reg       <= '0;
      tmr_reg      <= '0;
      presc_reg    <= '0;
      cm_reg       <= '0;
      slot_reg     <= '0;
      to_flag_reg  <= 1'b0;
      one_shot_reg <= 1'b0;
      trig_reg     <= '0;
      valid_reg    <= '0;
      first_reg    <= '1;
      timeout_reg  <= '0;
      near_reg     <= '0;
      for (int i = 0; i < N_CH; i++) avg_reg[i] <= '0;
    end else begin
      state_reg    <= state_next;
      ch_reg       <= ch_next;
      tmr_reg      <= tmr_next;
      presc_reg    <= presc_next;
      cm_reg       <= cm_next;
      slot_reg     <= slot_next;
      to_flag_reg  <= to_flag_next;
      one_shot_reg <= one_shot_next;
      trig_reg     <= trig_next;
      valid_reg    <= valid_next;
      first_reg    <= first_next;
      timeout_reg  <= timeout_next;
      near_reg     <= near_next;
      avg_reg      <= avg_next;
    end
  end

  assign bus.trig    = trig_reg;
  assign bus.valid   = valid_reg;
  assign bus.timeout = timeout_reg;
  assign bus.near    = near_reg;
  assign bus.busy    = (state_reg != IDLE);
endmodule

// File: tb/tb_us_ranger_array.sv
`timescale 1ns/1ps
// Bench for us_ranger_array at a scaled clock (500 kHz, 2 us per cycle) so that
// whole slots fit in a short run. Echo widths are driven in whole cycles on the
// falling clock edge; a behavioural model of the averaged ranges is kept here.
module tb_us_ranger_array;
  localparam int N_CH       = 2;
  localparam int CLK_HZ     = 500_000;
  localparam int TRIG_US    = 10;
  localparam int TIMEOUT_US = 5000;
  localparam int SLOT_MS    = 6;
  localparam int DIST_W     = 6;
  localparam int AVG_LOG2   = 2;
  localparam int NEAR_CM    = 20;

  // Derived by hand at 2 us per cycle.
  localparam int TRIG_CYC = 5;      // 10 us
  localparam int CM_CYC   = 29;     // 58 us per cm
  localparam int TO_CYC   = 2500;   // 5 ms
  localparam int SLOT_CYC = 3000;   // 6 ms
  localparam int DMAX     = 63;     // 2^6 - 1

  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;
  int   last_rise = 0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  us_ranger_array_if #(.N_CH(N_CH), .DIST_W(DIST_W)) bus ();

  us_ranger_array #(
    .N_CH(N_CH), .CLK_HZ(CLK_HZ), .TRIG_US(TRIG_US), .TIMEOUT_US(TIMEOUT_US),
    .SLOT_MS(SLOT_MS), .DIST_W(DIST_W), .AVG_LOG2(AVG_LOG2), .NEAR_CM(NEAR_CM)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Reference state: filtered range, first-sample flag, timeout and near flags.
  int m_avg   [N_CH];
  bit m_first [N_CH];
  bit m_to    [N_CH];
  bit m_near  [N_CH];

  task automatic model_reset();
    for (int i = 0; i < N_CH; i++) begin
      m_avg[i] = 0; m_first[i] = 1'b1; m_to[i] = 1'b0; m_near[i] = 1'b0;
    end
  endtask

  // Floor division by the filter weight.
  function automatic int floor_div(input int d);
    int w, q;
    w = 1 << AVG_LOG2;
    q = d / w;
    if ((d % w != 0) && (d < 0)) q = q - 1;
    return q;
  endfunction

  // width = 0 means the sensor never answered.
  task automatic model_sample(input int ch, input int width);
    int s;
    if (width == 0) begin
      m_to[ch] = 1'b1;
    end else begin
      s = width / CM_CYC;
      if (s > DMAX) s = DMAX;
      if (m_first[ch]) m_avg[ch] = s;
      else m_avg[ch] = m_avg[ch] + floor_div(s - m_avg[ch]);
      m_first[ch] = 1'b0;
      m_to[ch]    = 1'b0;
      m_near[ch]  = (m_avg[ch] < NEAR_CM);
    end
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_model(input string tag);
    logic [N_CH*DIST_W-1:0] d;
    logic [N_CH-1:0] t, n;
    for (int i = 0; i < N_CH; i++) begin
      d[i*DIST_W +: DIST_W] = DIST_W'(m_avg[i]);
      t[i] = m_to[i];
      n[i] = m_near[i];
    end
    chk({tag, "_dist"}, bus.distance, d);
    chk({tag, "_tout"}, bus.timeout, t);
    chk({tag, "_near"}, bus.near, n);
    $display("txn %s: distance=%h timeout=%b near=%b", tag, bus.distance, bus.timeout, bus.near);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_trig"}, bus.trig, 0);
    chk({tag, "_dist"}, bus.distance, 0);
    chk({tag, "_valid"}, bus.valid, 0);
    chk({tag, "_tout"}, bus.timeout, 0);
    chk({tag, "_near"}, bus.near, 0);
    chk({tag, "_busy"}, bus.busy, 0);
  endtask

  task automatic pulse_measure();
    bus.measure = 1'b1;
    @(negedge clk);
    bus.measure = 1'b0;
  endtask

  // One slot: wait for the channel's trigger, check its width and the slot
  // period, drive an echo of `width` cycles (0 = none), then check the result.
  task automatic do_slot(input int ch, input int dly, input int width, input int exp_period);
    int n, w;
    logic [N_CH-1:0] oh;
    oh = '0;
    oh[ch] = 1'b1;
    n = 0;
    while (bus.trig == '0 && n < 4000) begin @(negedge clk); n++; end
    chk("trig_sel", bus.trig, oh);
    if (exp_period > 0) chk("slot_period", cyc - last_rise, exp_period);
    last_rise = cyc;
    w = 0;
    while (bus.trig[ch] && w < 100) begin @(negedge clk); w++; end
    chk("trig_width", w, TRIG_CYC);
    repeat (dly) @(negedge clk);
    if (width > 0) begin
      bus.echo[ch] = 1'b1;
      repeat (width) @(negedge clk);
      bus.echo[ch] = 1'b0;
    end
    n = 0;
    while (bus.valid == '0 && n < 4000) begin @(negedge clk); n++; end
    chk("valid_sel", bus.valid, oh);
    chk("trig_quiet", bus.trig, 0);
    model_sample(ch, width);
    if (width > 0) chk("valid_latency", n, 4);
    else chk("timeout_latency_ok", (n >= TO_CYC && n <= TO_CYC + 2), 1);
    chk_model($sformatf("ch%0d_w%0d", ch, width));
    @(negedge clk);
    chk("valid_pulse", bus.valid, 0);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (bus.busy && n < 4000) begin @(negedge clk); n++; end
    chk("idle", bus.busy, 0);
  endtask

  initial begin
    int n;
    rst = 1'b1;
    bus.enable  = 1'b0;
    bus.measure = 1'b0;
    bus.echo    = '0;
    model_reset();
    repeat (3) @(negedge clk);
    chk_zero("reset");
    rst = 1'b0;
    @(negedge clk);
    chk("idle_after_reset", bus.busy, 0);

    // Single sweep: 10 cm on ch0, no answer on ch1.
    pulse_measure();
    chk("measure_to_trig", bus.trig, 1);
    chk("busy_on", bus.busy, 1);
    do_slot(0, 10, 10 * CM_CYC, 0);
    do_slot(1, 0, 0, SLOT_CYC);
    wait_idle();
    repeat (5) @(negedge clk);
    chk("no_retrigger", bus.trig, 0);

    // Random sweep; ch1 gets its first good sample and clears its timeout.
    pulse_measure();
    do_slot(0, $urandom_range(1, 100), $urandom_range(30, 2000), 0);
    do_slot(1, $urandom_range(1, 100), $urandom_range(30, 2000), SLOT_CYC);
    wait_idle();

    // Saturating echo on ch0; a measure pulse while busy must be ignored.
    pulse_measure();
    do_slot(0, 20, 2200, 0);
    pulse_measure();
    do_slot(1, $urandom_range(1, 100), $urandom_range(30, 2000), SLOT_CYC);
    wait_idle();

    // Continuous mode for three sweeps, then enable drops during a ch0 slot.
    bus.enable = 1'b1;
    @(negedge clk);
    for (int s = 0; s < 6; s++)
      do_slot(s % 2, $urandom_range(1, 100), $urandom_range(30, 2000), (s == 0) ? 0 : SLOT_CYC);
    do_slot(0, $urandom_range(1, 100), $urandom_range(30, 2000), SLOT_CYC);
    bus.enable = 1'b0;
    wait_idle();
    chk("drop_slot_len", cyc - last_rise, SLOT_CYC);
    chk("drop_no_ch1", bus.trig, 0);

    // Reset while a trigger pulse is high.
    pulse_measure();
    chk("pre_rst_trig", bus.trig, 1);
    rst = 1'b1;
    #1;
    chk_zero("rst_in_trig");
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Reset in the middle of an echo.
    pulse_measure();
    n = 0;
    while (bus.trig != '0 && n < 100) begin @(negedge clk); n++; end
    chk("trig_fell", bus.trig, 0);
    repeat (5) @(negedge clk);
    bus.echo[0] = 1'b1;
    repeat (100) @(negedge clk);
    chk("busy_in_measure", bus.busy, 1);
    rst = 1'b1;
    #1;
    chk_zero("rst_in_measure");
    bus.echo = '0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Restart at ch0: 60 cm taken unfiltered, then 12 cm filtered to 48.
    pulse_measure();
    do_slot(0, 15, 60 * CM_CYC + 7, 0);
    do_slot(1, $urandom_range(1, 100), $urandom_range(30, 2000), SLOT_CYC);
    wait_idle();
    pulse_measure();
    do_slot(0, 15, 12 * CM_CYC + 3, 0);
    do_slot(1, $urandom_range(1, 100), $urandom_range(30, 2000), SLOT_CYC);
    wait_idle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/us_ranger_array.md
# us_ranger_array

Multi-channel ultrasonic range finder; successor to the single-sensor `sensor_driver` / debounce pair. Drives up to `N_CH` HC-SR04-style sensors round-robin so their pulses never overlap. Converts echo width directly to centimetres, flags timeouts, and smooths each channel with a first-order IIR filter. Raises a per-channel `near` flag for the drive FSM. Sits between the GPIO echo/trigger pins and the top-level FSM, clocked from `clk_50`.

## Interface
- `N_CH`, 2: number of sensor channels (1..8)
- `CLK_HZ`, 50_000_000: clock frequency
- `TRIG_US`, 10: trigger pulse width
- `TIMEOUT_US`, 30000: max time from trigger fall to echo fall
- `SLOT_MS`, 60: minimum slot length per channel, from trigger rise to next trigger rise
- `DIST_W`, 9: distance width in cm; saturates at 2^DIST_W-1
- `AVG_LOG2`, 2: IIR shift (filter weight 1/2^AVG_LOG2; 0 = no filtering)
- `NEAR_CM`, 20: obstacle threshold
- `clk` in 1: system clock (50 MHz). One clock domain; reset is asynchronous and active-high.
- `rst` in 1: asynchronous, active-high reset
- `enable` in 1: continuous round-robin measurement while high
- `measure` in 1: single-cycle pulse; starts one sweep of all channels when idle
- `echo` in N_CH: raw echo inputs, asynchronous
- `trig` out N_CH: trigger outputs
- `distance` out N_CH*DIST_W: filtered distance per channel; ch k at [k*DIST_W +: DIST_W]
- `valid` out N_CH: one-cycle pulse when `distance[k]` updates
- `timeout` out N_CH: sticky per channel; set on timeout, cleared by next good sample
- `near` out N_CH: high while filtered distance < `NEAR_CM`
- `busy` out 1: high in any state other than IDLE

## Operation
- Every `echo` bit passes through a 2-flop synchronizer. A third register supplies edge detection.
- Derived constants: `TRIG_CYC = TRIG_US*CLK_HZ/1e6`, `CM_CYC = 58*CLK_HZ/1e6` (2900 at 50 MHz), `TO_CYC`, `SLOT_CYC`.
- FSM states and transitions:
  - IDLE → TRIG on `enable` or `measure`. Starts at ch 0 after reset or idle.
  - TRIG: `trig[ch]` high for exactly `TRIG_CYC` cycles, then → WAIT_RISE.
  - WAIT_RISE: waits for a synced rising edge. An echo already high must first fall. Timeout counter `TO_CYC` expiry → DONE with timeout.
  - MEASURE: a prescaler counts `CM_CYC` cycles, and each wrap increments the cm counter, which saturates at max. On the synced falling edge → DONE. The timeout counter keeps running, and expiry → DONE with timeout.
  - DONE: single cycle; updates channel state → HOLD.
  - HOLD: waits until the slot counter, started at trigger rise, reaches `SLOT_CYC`. Then advances to the next channel (wrapping `N_CH-1` → 0) → TRIG. The exception is when the last sweep channel is finished and `enable` is low, which → IDLE.
- Good sample `s`:
  - If it is the first sample since reset, `avg = s`.
  - Otherwise `avg = avg + ((s - avg) >>> AVG_LOG2)`, computed signed at DIST_W+1 bits.
  - Also: `valid[ch]` pulses and `timeout[ch]` clears.
- Timeout sample: `avg` is unchanged, `timeout[ch]` is set, `valid[ch]` pulses, and `near` is unchanged.
- `near[ch]` is recomputed from the new `avg` in the same update.
- `measure` while busy is ignored. If `enable` falls mid-slot, the current slot completes, then the FSM goes to IDLE.
- Reset values: `trig`=0, `distance`=0, `valid`=0, `timeout`=0, `near`=0, `busy`=0. The FSM is in IDLE, ch=0, and the first-sample flags are set.
- Reset mid-operation drops `trig` asynchronously and discards the in-flight sample.

## Timing
- `trig` rises 1 cycle after `measure`/`enable` is sampled in IDLE.
- Echo-to-internal latency is 3 cycles, with matching delay on both edges.
- The width error is at most one `CM_CYC` period, truncated.
- `valid`, `distance`, `near` and `timeout` all update in the same cycle, 1 cycle after DONE, which is 4 cycles after the raw echo fall.
- `valid` is never high on more than one channel in a cycle.
- Sweep period is `N_CH*SLOT_CYC` when each echo finishes within its slot. Otherwise HOLD is 0 cycles and the slot lengthens.

## Structure
- `us_pkg` holds:
  - the state enum (IDLE, TRIG, WAIT_RISE, MEASURE, DONE, HOLD)
  - the cycle-count function `us_to_cyc(us, clk_hz)`
  - `CM_PER_US_DIV` = 58
- Sub-module `us_echo_sync`: one per channel, generated. It contains the 2-flop synchronizer plus rise/fall pulse outputs.
- A single shared timer/prescaler serves all channels. Per-channel storage is only `avg`, the first flag, `timeout` and `near`.

## Test plan
- `measure` pulse, `N_CH`=2, ch0 echo 580 µs → `trig[0]` high exactly 500 cycles; `distance[0]`=10, `valid[0]` one pulse, `near[0]`=1.
- ch0 never echoes → `valid[0]` pulses 30 ms after `trig[0]` falls; `timeout[0]`=1, `distance[0]` unchanged; ch1 is then triggered.
- `AVG_LOG2`=2: samples 100 cm then 20 cm → `distance[0]`=100, then 80; `near[0]`=0 both times.
- Echo 40 ms long with `TIMEOUT_US` raised to 50000 → `distance` saturates at 511, no timeout.
- `enable` held high for 3 sweeps → triggers alternate ch0/ch1 every 60 ms with no overlap. `enable` dropped mid-slot → the slot finishes, then `busy`=0.
- `rst` asserted during MEASURE → `trig`=0 immediately, all outputs 0. The next `measure` starts at ch0 and takes the first sample without filtering.
